// File: rtl/sparse_link.sv
// sparse_link: byte-serial link for sparse row/column packets {nnz, values, indices}.
// Define SPARSE_LINK_CHECKSUM_EN to append and verify a trailing XOR checksum byte.
module sparse_link #(
  parameter  int unsigned MATRIX_N  = 4,
  parameter  int unsigned HEADER    = 1,
  parameter  int unsigned VAL_BYTES = 2,
  parameter  int unsigned IDX_BYTES = 2,
  localparam int unsigned DW        = 8 * (HEADER + MATRIX_N * (VAL_BYTES + IDX_BYTES))
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          op_i,
  input  logic          rx_ready_i,
  input  logic [7:0]    rx_byte_i,
  input  logic          tx_go_i,
  input  logic [DW-1:0] tx_data_i,
  input  logic          tx_ready_i,
  output logic [7:0]    tx_byte_o,
  output logic          tx_start_o,
  output logic [DW-1:0] rx_data_o,
  output logic          rx_valid_o,
  output logic          tx_done_o,
  output logic          err_o,
  output logic          busy_o
);
  localparam int unsigned HW = 8 * HEADER;
  localparam int unsigned VW = 8 * MATRIX_N * VAL_BYTES;
  localparam int unsigned IW = 8 * MATRIX_N * IDX_BYTES;
  localparam int unsigned CW = $clog2(DW / 8 + 2);
`ifdef SPARSE_LINK_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle, StRxHdr, StRxVal, StRxIdx, StRxChk, StRxDone,
    StTxLoad, StTxSend, StTxWait, StTxDone, StErr
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, total_q, total_d;
  logic [HW-1:0] nnz_q, nnz_d;
  logic [VW-1:0] val_q, val_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
  logic [7:0]    tx_byte_q, tx_byte_d, csum_q, csum_d;
  int unsigned   rx_nnz, tx_nnz, cnt;

  assign rx_nnz = 32'(nnz_q);
  assign tx_nnz = 32'(tx_buf_q[DW-1 -: HW]);
  assign cnt    = 32'(cnt_q);

  // Wire byte k of a packed packet carrying n entries; unused slots are skipped.
  function automatic logic [7:0] wire_byte(logic [DW-1:0] pkt, int unsigned n, int unsigned k);
    int unsigned sh;
    if (k < HEADER) sh = DW - 8 * (k + 1);
    else if (k < HEADER + n * VAL_BYTES) sh = VW + IW - 8 * (k - HEADER + 1);
    else sh = IW - 8 * (k - HEADER - n * VAL_BYTES + 1);
    return 8'(pkt >> sh);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    nnz_d     = nnz_q;
    val_d     = val_q;
    idx_d     = idx_q;
    rx_data_d = rx_data_q;
    tx_buf_d  = tx_buf_q;
    tx_byte_d = tx_byte_q;
    csum_d    = csum_q;
    unique case (state_q)
      StIdle: begin
        if (!op_i && rx_ready_i) begin
          nnz_d   = HW'(rx_byte_i);
          cnt_d   = CW'(1);
          val_d   = '0;
          idx_d   = '0;
          csum_d  = rx_byte_i;
          state_d = StRxHdr;
        end else if (op_i && tx_go_i) begin
          tx_buf_d = tx_data_i;
          state_d  = StTxLoad;
        end
      end
      StRxHdr: begin
        if (cnt == HEADER) begin
          cnt_d = '0;
          if (rx_nnz > MATRIX_N) state_d = StErr;
          else if (rx_nnz == 0) state_d = CsumEn ? StRxChk : StRxDone;
          else state_d = StRxVal;
        end else if (rx_ready_i) begin
          nnz_d  = HW'({nnz_q, rx_byte_i});
          cnt_d  = cnt_q + 1'b1;
          csum_d = csum_q ^ rx_byte_i;
        end
      end
      StRxVal: begin
        if (rx_ready_i) begin
          val_d  = val_q | (VW'(rx_byte_i) << (VW - 8 * (cnt + 1)));
          csum_d = csum_q ^ rx_byte_i;
          if (cnt == rx_nnz * VAL_BYTES - 1) begin
            cnt_d   = '0;
            state_d = StRxIdx;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRxIdx: begin
        if (rx_ready_i) begin
          idx_d  = idx_q | (IW'(rx_byte_i) << (IW - 8 * (cnt + 1)));
          csum_d = csum_q ^ rx_byte_i;
          if (cnt == rx_nnz * IDX_BYTES - 1) begin
            cnt_d   = '0;
            state_d = CsumEn ? StRxChk : StRxDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRxChk: begin
        if (rx_ready_i) state_d = (rx_byte_i == csum_q) ? StRxDone : StErr;
      end
      StTxLoad: begin
        cnt_d  = '0;
        csum_d = '0;
        if (tx_nnz > MATRIX_N) begin
          state_d = StErr;
        end else begin
          total_d   = CW'(HEADER + tx_nnz * (VAL_BYTES + IDX_BYTES) + 32'(CsumEn));
          tx_byte_d = wire_byte(tx_buf_q, tx_nnz, 0);
          state_d   = StTxSend;
        end
      end
      StTxSend: begin
        if (tx_ready_i) begin
          csum_d = csum_q ^ tx_byte_q;
          if (cnt == 32'(total_q) - 1) begin
            state_d = StTxDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StTxWait;
          end
        end
      end
      StTxWait: begin
        // The last slot of a checksummed packet carries the running XOR.
        tx_byte_d = (CsumEn && cnt == 32'(total_q) - 1) ? csum_q
                                                        : wire_byte(tx_buf_q, tx_nnz, cnt);
        state_d   = StTxSend;
      end
      StRxDone, StTxDone, StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StRxDone && state_q != StRxDone) rx_data_d = {nnz_d, val_d, idx_d};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      total_q   <= '0;
      nnz_q     <= '0;
      val_q     <= '0;
      idx_q     <= '0;
      rx_data_q <= '0;
      tx_buf_q  <= '0;
      tx_byte_q <= '0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      total_q   <= total_d;
      nnz_q     <= nnz_d;
      val_q     <= val_d;
      idx_q     <= idx_d;
      rx_data_q <= rx_data_d;
      tx_buf_q  <= tx_buf_d;
      tx_byte_q <= tx_byte_d;
      csum_q    <= csum_d;
    end
  end

  assign tx_byte_o  = tx_byte_q;
  assign tx_start_o = (state_q == StTxSend) && tx_ready_i;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = (state_q == StRxDone);
  assign tx_done_o  = (state_q == StTxDone);
  assign err_o      = (state_q == StErr);
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_sparse_link.sv
// tb_sparse_link: table-driven and randomized checks of sparse_link against a packet-level model.
module tb_sparse_link;
  localparam int N  = 4;
  localparam int DW = 8 * (1 + N * 4);

  typedef struct {
    int               nnz;
    logic [0:3][15:0] v;
    logic [0:3][15:0] x;
  } pkt_t;
  typedef struct {
    pkt_t          p;
    bit            exp_err;
    logic [DW-1:0] exp_data;
  } rx_vec_t;

  logic clk = 1'b0;
  logic rst_n, op, rx_ready, tx_go, tx_ready;
  logic [7:0] rx_byte, tx_byte;
  logic [DW-1:0] tx_data, rx_data;
  logic tx_start, rx_valid, tx_done, err, busy;

  int vectors = 0, miscompares = 0;
  int cyc = 0, rxv_cnt = 0, err_cnt = 0, txd_cnt = 0, rdy_viol = 0, adj_viol = 0;
  int last_start_cyc = 0, done_cyc = 0, rdy_mode = 0;
  bit prev_start = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  sparse_link dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .op_i      (op),
    .rx_ready_i(rx_ready),
    .rx_byte_i (rx_byte),
    .tx_go_i   (tx_go),
    .tx_data_i (tx_data),
    .tx_ready_i(tx_ready),
    .tx_byte_o (tx_byte),
    .tx_start_o(tx_start),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .tx_done_o (tx_done),
    .err_o     (err),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  // UART transmitter model: 0 = always idle, 1 = random, 2 = held busy.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        got_q.push_back(tx_byte);
        if (!tx_ready) rdy_viol++;
        if (prev_start) adj_viol++;
        last_start_cyc = cyc;
      end
      prev_start = tx_start;
      if (rx_valid) rxv_cnt++;
      if (err) err_cnt++;
      if (tx_done) begin
        txd_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed layout {nnz, values, indices}; full=0 zeroes slots at or beyond nnz.
  function automatic logic [DW-1:0] pack(input pkt_t p, input bit full);
    logic [DW-1:0] d;
    int lim;
    d = '0;
    lim = full ? N : ((p.nnz < N) ? p.nnz : N);
    d[DW-1 -: 8] = 8'(p.nnz);
    for (int k = 0; k < lim; k++) begin
      d[DW - 9 - 16 * k -: 16] = p.v[k];
      d[8 * N * 2 - 1 - 16 * k -: 16] = p.x[k];
    end
    return d;
  endfunction

  task automatic build_wire(input pkt_t p);
    exp_q.delete();
    exp_q.push_back(8'(p.nnz));
    if (p.nnz <= N) begin
      for (int k = 0; k < p.nnz; k++) begin
        exp_q.push_back(p.v[k][15:8]);
        exp_q.push_back(p.v[k][7:0]);
      end
      for (int k = 0; k < p.nnz; k++) begin
        exp_q.push_back(p.x[k][15:8]);
        exp_q.push_back(p.x[k][7:0]);
      end
`ifdef SPARSE_LINK_CHECKSUM_EN
      begin
        logic [7:0] cs;
        cs = '0;
        foreach (exp_q[i]) cs ^= exp_q[i];
        exp_q.push_back(cs);
      end
`endif
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    rx_byte  = 8'($urandom);
    @(posedge clk);
  endtask

  task automatic rx_run(input pkt_t p, input bit exp_err, input logic [DW-1:0] exp_data,
                        input string tag);
    int r0, e0;
    r0 = rxv_cnt;
    e0 = err_cnt;
    build_wire(p);
    op = 1'b0;
    if (p.nnz > N) send_rx(exp_q[0]);
    else foreach (exp_q[i]) send_rx(exp_q[i]);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_valid"}, rxv_cnt - r0, exp_err ? 0 : 1);
    check({tag, "_err"}, err_cnt - e0, exp_err ? 1 : 0);
    check({tag, "_data"}, rx_data, exp_data);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic tx_run(input pkt_t p, input bit stall, input string tag);
    int base, e0, d0, n0;
    bit stalled, done;
    build_wire(p);
    base = got_q.size();
    e0 = err_cnt;
    d0 = txd_cnt;
    stalled = 1'b0;
    done = 1'b0;
    @(posedge clk); #1;
    op = 1'b1;
    tx_go = 1'b1;
    tx_data = pack(p, 1'b1);
    @(posedge clk); #1;
    tx_go = 1'b0;
    tx_data = '1;
    for (int i = 0; i < 800 && !done; i++) begin
      @(posedge clk); #1;
      done = (txd_cnt != d0) || (err_cnt != e0);
      if (stall && !stalled && got_q.size() == base + 2) begin
        stalled = 1'b1;
        rdy_mode = 2;
        @(posedge clk); #1;
        n0 = got_q.size();
        repeat (10) begin @(posedge clk); #1; end
        check({tag, "_stall"}, got_q.size(), n0);
        rdy_mode = 0;
      end
    end
    check({tag, "_timeout"}, done, 1);
    if (p.nnz > N) begin
      check({tag, "_err"}, err_cnt - e0, 1);
      check({tag, "_nbytes"}, got_q.size() - base, 0);
      check({tag, "_done"}, txd_cnt - d0, 0);
    end else begin
      check({tag, "_done"}, txd_cnt - d0, 1);
      check({tag, "_err"}, err_cnt - e0, 0);
      check({tag, "_nbytes"}, got_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        if (base + i < got_q.size()) check({tag, "_byte"}, got_q[base + i], exp_q[i]);
      check({tag, "_done_after_last"}, done_cyc > last_start_cyc, 1);
    end
    check({tag, "_start_while_busy"}, rdy_viol, 0);
    check({tag, "_back_to_back"}, adj_viol, 0);
    op = 1'b0;
  endtask

  function automatic pkt_t rand_pkt(input bit allow_bad);
    pkt_t p;
    p.nnz = $urandom_range(0, N);
    if (allow_bad && $urandom_range(0, 5) == 0) p.nnz = $urandom_range(N + 1, 255);
    for (int k = 0; k < N; k++) begin
      p.v[k] = 16'($urandom);
      p.x[k] = 16'($urandom);
    end
    return p;
  endfunction

  initial begin
    rx_vec_t tbl[6];
    pkt_t p;
    logic [DW-1:0] exp_rx;
    int r0, e0, b;

    tbl[0] = '{'{2, 64'h000A_000B_0000_0000, 64'h0001_0003_0000_0000}, 1'b0,
               136'h02_000A_000B_0000_0000_0001_0003_0000_0000};
    tbl[1] = '{'{5, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 1'b1,
               136'h02_000A_000B_0000_0000_0001_0003_0000_0000};
    tbl[2] = '{'{0, 64'h0, 64'h0}, 1'b0, 136'h0};
    tbl[3] = '{'{4, 64'h1111_2222_3333_4444, 64'h0000_0001_0002_0003}, 1'b0,
               136'h04_1111_2222_3333_4444_0000_0001_0002_0003};
    tbl[4] = '{'{255, 64'h0, 64'h0}, 1'b1,
               136'h04_1111_2222_3333_4444_0000_0001_0002_0003};
    tbl[5] = '{'{1, 64'hABCD_FFFF_FFFF_FFFF, 64'h0003_EEEE_EEEE_EEEE}, 1'b0,
               136'h01_ABCD_0000_0000_0000_0003_0000_0000_0000};

    rst_n = 1'b0; op = 1'b0; rx_ready = 1'b0; rx_byte = '0; tx_go = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_strobes", {tx_start, rx_valid, tx_done, err}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++)
      rx_run(tbl[i].p, tbl[i].exp_err, tbl[i].exp_data, $sformatf("tbl%0d", i));

    // rx_ready is ignored while op selects transmit.
    r0 = rxv_cnt;
    op = 1'b1;
    send_rx(8'h02);
    #1;
    check("op1_rx_ignored_busy", busy, 0);
    op = 1'b0;
    send_rx(8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("op1_rx_ignored_valid", rxv_cnt - r0, 1);
    check("op1_rx_ignored_data", rx_data, 0);

    // Reset mid-packet: partial packet is dropped, next full packet lands.
    rx_run(tbl[5].p, 1'b0, tbl[5].exp_data, "pre_rst");
    r0 = rxv_cnt;
    build_wire(tbl[0].p);
    for (int i = 0; i < 3; i++) send_rx(exp_q[i]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_quiet", rxv_cnt - r0, 0);
    check("post_rst_data0", rx_data, 0);
    rx_run(tbl[0].p, 1'b0, tbl[0].exp_data, "post_rst");
    check("rst_only_second_valid", rxv_cnt - r0, 1);

`ifdef SPARSE_LINK_CHECKSUM_EN
    begin
      logic [47:0] good;
      logic [47:0] bad;
      good = 48'h01_0005_0000_04;
      bad  = 48'h01_0005_0000_05;
      r0 = rxv_cnt;
      e0 = err_cnt;
      for (int i = 5; i >= 0; i--) send_rx(good[8 * i +: 8]);
      repeat (3) @(posedge clk);
      #1;
      check("csum_good_valid", rxv_cnt - r0, 1);
      check("csum_good_data", rx_data, 136'h01_0005_0000_0000_0000_0000_0000_0000_0000);
      for (int i = 5; i >= 0; i--) send_rx(bad[8 * i +: 8]);
      repeat (3) @(posedge clk);
      #1;
      check("csum_bad_err", err_cnt - e0, 1);
      check("csum_bad_novalid", rxv_cnt - r0, 1);
      check("csum_bad_data", rx_data, 136'h01_0005_0000_0000_0000_0000_0000_0000_0000);
    end
`endif

    exp_rx = rx_data;
    for (int i = 0; i < 15; i++) begin
      p = rand_pkt(1'b1);
      if (p.nnz <= N) exp_rx = pack(p, 1'b0);
      rx_run(p, p.nnz > N, exp_rx, $sformatf("rnd_rx%0d", i));
    end

    rdy_mode = 0;
    b = got_q.size();
    p = '{1, 64'h1234_5555_6666_7777, 64'h0002_8888_9999_AAAA};
    tx_run(p, 1'b0, "tx_n1");
`ifndef SPARSE_LINK_CHECKSUM_EN
    check("tx_n1_len", got_q.size() - b, 5);
    if (got_q.size() >= b + 5)
      check("tx_n1_bytes", {got_q[b], got_q[b+1], got_q[b+2], got_q[b+3], got_q[b+4]},
            40'h01_1234_0002);
`endif
    tx_run('{4, 64'hA1A2_B1B2_C1C2_D1D2, 64'h0000_0001_0002_0003}, 1'b1, "tx_stall");
    tx_run('{5, 64'h0, 64'h0}, 1'b0, "tx_bad");
    tx_run('{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, "tx_n0");
    check("tx_rx_data_untouched", rx_data, exp_rx);

    rdy_mode = 1;
    for (int i = 0; i < 12; i++) tx_run(rand_pkt(1'b1), 1'b0, $sformatf("rnd_tx%0d", i));
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sparse_link.md
SPARSE_LINK -- requirements
Module: sparse_link

Interface
REQ-001 SHALL have parameter MATRIX_N, default 4: maximum nonzeros per row/col packet (1..255).
REQ-002 SHALL have parameter HEADER, default 1: nnz header width in bytes (1..2).
REQ-003 SHALL have parameter VAL_BYTES, default 2: bytes per value entry.
REQ-004 SHALL have parameter IDX_BYTES, default 2: bytes per index entry.
REQ-005 SHALL define DW = 8*(HEADER + MATRIX_N*(VAL_BYTES+IDX_BYTES)) as the packed data width.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  system clock, rising edge.
REQ-008 resetn  in  1  asynchronous active-low reset.
REQ-009 op  in  1  direction, sampled in IDLE only: 0 = receive, 1 = transmit.
REQ-010 rx_ready  in  1  one-cycle strobe; rx_byte is valid.
REQ-011 rx_byte  in  8  received byte.
REQ-012 tx_go  in  1  one-cycle request to transmit tx_data.
REQ-013 tx_data  in  DW  packet to send, same layout as rx_data.
REQ-014 tx_ready  in  1  UART transmitter idle.
REQ-015 tx_byte  out  8  byte to transmit.
REQ-016 tx_start  out  1  one-cycle strobe; tx_byte is valid.
REQ-017 rx_data  out  DW  {nnz, values[0..N-1], indices[0..N-1]}, entry 0 most significant within each field.
REQ-018 rx_valid / tx_done / err  out  1 each  one-cycle completion and error strobes.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 Wire order: nnz header MSB first, then nnz values, then nnz indices; each entry MSB first; no padding bytes on the wire.
REQ-021 States: IDLE, RX_HDR, RX_VAL, RX_IDX, RX_CHK, RX_DONE, TX_LOAD, TX_SEND, TX_WAIT, TX_DONE, ERR.
REQ-022 IDLE: op=0 with rx_ready -> capture byte, go to RX_HDR; op=1 with tx_go -> TX_LOAD; rx_ready while op=1 is ignored.
REQ-023 After HEADER bytes: nnz>MATRIX_N -> ERR; nnz=0 -> RX_CHK (or RX_DONE); otherwise -> RX_VAL.
REQ-024 RX_VAL consumes exactly nnz*VAL_BYTES bytes, then RX_IDX consumes exactly nnz*IDX_BYTES bytes; byte counter width derived from DW.
REQ-025 RX_DONE: rx_data updates atomically; unused slots (k>=nnz) are zero; rx_valid pulses for one cycle the same cycle; next state IDLE.
REQ-026 rx_data SHALL hold its value until the next RX_DONE or reset; partial or aborted packets never alter it.
REQ-027 TX_LOAD latches tx_data; nnz>MATRIX_N -> ERR with no bytes sent.
REQ-028 TX_SEND asserts tx_start for one cycle only when tx_ready=1; TX_WAIT waits one cycle, then waits for tx_ready=1 before the next byte.
REQ-029 Transmit byte count = HEADER + nnz*(VAL_BYTES+IDX_BYTES) (+1 with checksum); after the final byte is accepted -> TX_DONE, which pulses tx_done for one cycle and returns to IDLE.
REQ-030 ERR pulses err for one cycle, then returns to IDLE; remaining bytes of a bad rx packet are treated as new-packet starts (the host resynchronises).
REQ-031 tx_go outside IDLE is ignored; op changes outside IDLE are ignored.

Reset
REQ-032 Reset, including mid-packet, aborts immediately: state IDLE, counters 0, tx_start/rx_valid/tx_done/err 0, tx_byte 0, rx_data 0, busy 0; no strobe follows release.

Configuration
REQ-033 Macro SPARSE_LINK_CHECKSUM_EN defined: the sender appends one byte equal to the XOR of all preceding packet bytes; the receiver checks that byte in RX_CHK and goes to ERR on mismatch (rx_data unchanged, no rx_valid).
REQ-034 SPARSE_LINK_CHECKSUM_EN undefined: no checksum byte is sent or expected; RX_CHK is unreachable and error detection covers nnz range only.

Verification
REQ-035 Defaults, no checksum: rx bytes 02, 00 0A, 00 0B, 00 01, 00 03 -> rx_valid; rx_data nnz=2, val0=000A, val1=000B, idx0=0001, idx1=0003, others 0.
REQ-036 Rx header 05 with MATRIX_N=4 -> err pulse, rx_data unchanged, no rx_valid.
REQ-037 Tx with nnz=1, val=1234, idx=0002, tx_ready held 1 -> tx_bytes 01,12,34,00,02, separated by at least 1 idle cycle each; tx_done after the last byte.
REQ-038 Checksum on, rx 01 00 05 00 00 plus checksum 04 -> rx_valid; same packet with checksum 05 -> err.
REQ-039 resetn low after 3 rx bytes, then a full valid packet -> only the second packet produces rx_valid; rx_data is 0 in between.
REQ-040 tx_ready held low 10 cycles mid-tx -> no tx_start while low; byte sequence intact.
